gf256_serial_mult: RTL and testbench



---
 rtl/aes_gf_pkg.sv | 16 +
 rtl/gf_xtime.sv | 16 +
 rtl/gf256_serial_mult.sv | 112 +++++++++++
 tb/tb_gf256_serial_mult.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) definitions for the AES datapath blocks.
package aes_gf_pkg;

  // Low 8 bits of x^8 + x^4 + x^3 + x + 1; the x^8 term is implicit.
  localparam logic [7:0] GF_POLY_LO = 8'h1B;

  typedef logic [7:0] gf8_t;

  // Serial multiplier FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/gf_xtime.sv
// Combinational multiply-by-x in GF(2^8): shift left, fold the carried-out
// x^8 term back in with the low bits of the reduction polynomial.
module gf_xtime
  import aes_gf_pkg::*;
(
  input  gf8_t a,
  input  gf8_t poly_lo,
  output gf8_t y
);

  // Shift and conditionally reduce.
  always_comb begin
    y = {a[6:0], 1'b0} ^ (a[7] ? poly_lo : 8'h00);
  end

endmodule

// File: rtl/gf256_serial_mult.sv
// Iterative GF(2^8) multiplier, one multiplier bit per clock.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE. Once
// out_valid rises, out_p is held until the consumer takes it with out_ready.
// The state is fully visible on in_ready / busy / out_valid (one-hot).
module gf256_serial_mult
  import aes_gf_pkg::*;
#(
  parameter logic [7:0] POLY_LO    = GF_POLY_LO,
  parameter bit         EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_p,
  output logic       busy
);

  mult_state_e state_q, state_d;
  gf8_t        a_q, a_d;
  gf8_t        b_q, b_d;
  gf8_t        p_q, p_d;
  logic [2:0]  cnt_q, cnt_d;

  gf8_t a_xt;
  gf8_t b_shift;

  gf_xtime u_xtime (
    .a       (a_q),
    .poly_lo (POLY_LO),
    .y       (a_xt)
  );

  // Multiplier bits still to process after this iteration.
  always_comb begin
    b_shift = {1'b0, b_q[7:1]};
  end

  // Next-state, operand load and shift-and-add iteration.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          p_d   = 8'h00;
          cnt_d = 3'd0;
          // A zero multiplier needs no iterations when early exit is on.
          if (EARLY_EXIT && (in_b == 8'h00)) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        p_d   = p_q ^ (b_q[0] ? a_q : 8'h00);
        a_d   = a_xt;
        b_d   = b_shift;
        cnt_d = cnt_q + 3'd1;
        if ((cnt_q == 3'd7) || (EARLY_EXIT && (b_shift == 8'h00))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      p_q     <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status and handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
    out_p     = p_q;
  end

endmodule

// File: tb/tb_gf256_serial_mult.sv
// Bench for gf256_serial_mult: one instance with constant latency, one with
// early exit. Expected products are queued at issue time and popped by a
// monitor whenever a product handshake occurs.
module tb_gf256_serial_mult;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: EARLY_EXIT=0
  logic       in_valid0 = 1'b0, out_ready0 = 1'b1;
  logic [7:0] in_a0 = 8'h00, in_b0 = 8'h00;
  logic       in_ready0, out_valid0, busy0;
  logic [7:0] out_p0;
  // Instance 1: EARLY_EXIT=1
  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [7:0] in_a1 = 8'h00, in_b1 = 8'h00;
  logic       in_ready1, out_valid1, busy1;
  logic [7:0] out_p1;

  gf256_serial_mult #(.POLY_LO(8'h1B), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_p(out_p0), .busy(busy0)
  );

  gf256_serial_mult #(.POLY_LO(8'h1B), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_p(out_p1), .busy(busy1)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Full polynomial product, then reduce modulo x^8+x^4+x^3+x+1 by long division.
  function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
    return prod[7:0];
  endfunction

  // Edges after the accepting edge until out_valid. Without early exit this
  // is always 8. With early exit it is (highest set bit index + 1); a zero
  // multiplier lands in DONE on the accepting edge itself.
  function automatic int lat_ref(input int sel, input logic [7:0] b);
    if (sel == 0) return 8;
    for (int i = 7; i >= 0; i--)
      if (b[i]) return i + 1;
    return 0;
  endfunction

  function automatic bit rdy(input int sel);
    return (sel == 0) ? in_ready0 : in_ready1;
  endfunction
  function automatic bit ov(input int sel);
    return (sel == 0) ? out_valid0 : out_valid1;
  endfunction
  function automatic bit bz(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (sel == 0) begin in_valid0 = v; in_a0 = a; in_b0 = b; end
    else          begin in_valid1 = v; in_a1 = a; in_b1 = b; end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase with
  // out_valid high (or after the cycle budget expires).
  task automatic issue(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input bit wiggle);
    int  n;
    bit  seen;
    n = 0;
    while (!rdy(sel) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!rdy(sel)) begin
      check($sformatf("dut%0d in_ready before issue", sel), 0, 1);
      return;
    end
    if (sel == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
    drive(sel, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, a, b);
    n    = 0;
    seen = ov(sel);
    if (!seen) check($sformatf("dut%0d busy after accept", sel), bz(sel), 1);
    while (!seen && n < 20) begin
      if (wiggle)
        drive(sel, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      @(posedge clk); #1; n++;
      seen = ov(sel);
    end
    drive(sel, 1'b0, 8'h00, 8'h00);
    check($sformatf("dut%0d latency a=%0h b=%0h", sel, a, b), seen ? n : -1, lat_ref(sel, b));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready0) begin
      if (exp_q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0 unexpected product: got %0h expected none", out_p0);
      end else check("dut0 product", out_p0, exp_q0.pop_front());
    end
    if (!rst && out_valid1 && out_ready1) begin
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected product: got %0h expected none", out_p1);
      end else check("dut1 product", out_p1, exp_q1.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ra, rb;
    int n;
    repeat (3) @(posedge clk);
    #1;
    // Reset values, still in reset and after release.
    check("dut0 reset in_ready", in_ready0, 1);
    check("dut0 reset out_valid", out_valid0, 0);
    check("dut0 reset busy", busy0, 0);
    check("dut0 reset out_p", out_p0, 8'h00);
    check("dut1 reset in_ready", in_ready1, 1);
    check("dut1 reset out_valid", out_valid1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, constant latency.
    issue(0, 8'h57, 8'h83, 8'hC1, 1'b0);
    issue(0, 8'h57, 8'h13, 8'hFE, 1'b0);
    issue(0, 8'h02, 8'h80, 8'h1B, 1'b0);
    issue(0, 8'hA5, 8'h01, 8'hA5, 1'b0);
    issue(0, 8'h00, 8'hFF, 8'h00, 1'b0);

    // Directed vectors, early exit.
    issue(1, 8'h57, 8'h13, 8'hFE, 1'b0);
    issue(1, 8'hA5, 8'h00, 8'h00, 1'b0);
    issue(1, 8'h57, 8'h83, 8'hC1, 1'b0);
    issue(1, 8'h02, 8'h80, 8'h1B, 1'b0);
    issue(1, 8'hA5, 8'h01, 8'hA5, 1'b0);

    // Backpressure: product held for 5 cycles.
    out_ready0 = 1'b0;
    issue(0, 8'h57, 8'h83, 8'hC1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp out_valid held", out_valid0, 1);
      check("bp out_p stable", out_p0, 8'hC1);
      check("bp in_ready low", in_ready0, 0);
    end
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready", in_ready0, 1);
    check("bp release out_valid", out_valid0, 0);
    check("bp release out_p kept", out_p0, 8'hC1);

    // Reset on the 4th BUSY edge aborts the operation.
    drive(0, 1'b1, 8'h57, 8'h83);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready", in_ready0, 1);
    check("abort out_valid", out_valid0, 0);
    check("abort busy", busy0, 0);
    check("abort out_p", out_p0, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort no product", out_valid0, 0);
    end
    issue(0, 8'h03, 8'h03, 8'h05, 1'b0);

    // Operand hold: inputs toggled while busy.
    issue(0, 8'h57, 8'h83, 8'hC1, 1'b1);
    issue(1, 8'h57, 8'h13, 8'hFE, 1'b1);

    // Random sweep against the reference model.
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      issue(0, ra, rb, gf_mul_ref(ra, rb), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 64; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      issue(1, ra, rb, gf_mul_ref(ra, rb), 1'($urandom_range(0, 1)));
    end

    // Drain and report.
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("dut0 queue drained", exp_q0.size(), 0);
    check("dut1 queue drained", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
